fir_tap_ctrl: RTL and testbench
===============================

FIR_TAP_CTRL -- requirements
Module: fir_tap_ctrl

Interface
REQ-001 Parameters SHALL be: TAPS, default 4, tap count of the controlled moving-sum tap; WIDTH, default 4, sample width; DEPTH, default 8, output FIFO depth (DEPTH >= TAPS).
REQ-002 OW SHALL equal $clog2(TAPS)+WIDTH.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  upstream ready.
- s_data  in  WIDTH  upstream sample.
- flush_req  in  1  single-cycle pulse requesting a flush.
- flush_done  out  1  single-cycle pulse when the flush has completed.
- busy  out  1  high whenever state is not RUN.
- tap_reset  out  1  active-high synchronous reset to the tap.
- tap_valid  out  1  tap in_valid.
- tap_data  out  WIDTH  tap input.
- tap_out_valid  in  1  tap out_valid.
- tap_out  in  OW  tap sum.
- m_valid  out  1  downstream valid.
- m_ready  in  1  downstream ready.
- m_data  out  OW  downstream sum.
- stat_in_cnt  out  16  accepted-sample count.
- stat_out_cnt  out  16  delivered-sum count.

Function
REQ-004 The controller SHALL implement states INIT, RUN, FLUSH and DRAIN.
REQ-005 INIT SHALL last exactly TAPS cycles.
- tap_reset=1 and tap_valid=0 throughout INIT, so that both the tap data line and the tap valid line clear.
- INIT then SHALL transition to RUN.
REQ-006 In RUN, s_ready SHALL be high iff inflight+fifo_cnt < DEPTH.
- inflight counts samples issued to the tap and not yet returned.
- fifo_cnt is the output FIFO occupancy.
- Neither counter takes same-cycle pop credit.
REQ-007 On an s_valid&&s_ready cycle, tap_valid SHALL be 1 and tap_data SHALL be s_data, combinationally in that cycle, and inflight SHALL increment.
- Otherwise tap_valid=0 and tap_data=0.
REQ-008 Every tap_out_valid cycle SHALL write tap_out into the FIFO and decrement inflight.
- Simultaneous issue and return SHALL leave inflight unchanged.
REQ-009 m_valid SHALL be high iff fifo_cnt>0, with m_data at the FIFO head.
- A pop occurs on m_valid&&m_ready.
- A simultaneous push and pop SHALL leave fifo_cnt unchanged.
- Order SHALL be strictly preserved.
REQ-010 A sample accepted at edge k SHALL produce m_valid high after edge k+TAPS, given an empty FIFO.
REQ-011 flush_req in RUN SHALL transition to FLUSH at the next edge.
- flush_req SHALL take priority over s_valid: s_ready=0 in that cycle.
- flush_req outside RUN SHALL be ignored.
REQ-012 In FLUSH, s_ready SHALL be 0.
- The controller SHALL issue exactly TAPS zero samples (tap_valid=1, tap_data=0), each subject to the REQ-006 credit rule.
- FLUSH SHALL then transition to DRAIN.
REQ-013 DRAIN SHALL remain until inflight==0 and fifo_cnt==0.
- On exit, DRAIN SHALL pulse flush_done for one cycle and return to RUN.
- The flush tail sums SHALL be delivered downstream as normal data.
REQ-014 The FIFO SHALL never overflow, and inflight SHALL never exceed DEPTH; a FIFO write when full is a design error.

Reset
REQ-015 Assertion of reset SHALL, asynchronously, at any time including mid-FLUSH:
- Set state to INIT.
- Clear inflight, fifo_cnt, FIFO pointers and stat counters.
- Force s_ready=0, m_valid=0, flush_done=0, busy=1, tap_valid=0, tap_data=0, tap_reset=1 and m_data=0.
REQ-016 The INIT sequence SHALL start at the first clk edge after reset deasserts.
REQ-017 Returns still in flight at reset SHALL be discarded; INIT guarantees that none emerge afterwards.

Configuration
REQ-018 With macro FIR_TAP_CTRL_STATS_EN defined:
- stat_in_cnt SHALL increment on each s_valid&&s_ready.
- stat_out_cnt SHALL increment on each m_valid&&m_ready.
- Both SHALL be 16-bit and wrap from 16'hFFFF to 0.
- Flush zero samples SHALL NOT be counted by stat_in_cnt.
REQ-019 Without FIR_TAP_CTRL_STATS_EN, both stat ports SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-020 Benches SHALL use TAPS=4, WIDTH=4, DEPTH=8 and cover:
- Reset release -> busy=1 and tap_reset=1 for 4 cycles, then busy=0 and s_ready=1.
- Samples 1,2,3,4 with m_ready=1 -> m_data sequence 1,3,6,10, the first arriving 4 edges after acceptance.
- Continuous s_valid with m_ready=0 -> exactly 8 samples accepted, s_ready=0 thereafter; one m_ready pop re-enables exactly one accept.
- After samples 5,5,5,5, flush_req -> 4 zero issues, tail sums 15,10,5,0 delivered, flush_done pulses once, then RUN.
- reset asserted mid-FLUSH with 3 in flight -> all outputs reach reset values immediately; no stale m_valid after INIT.
- STATS_EN defined with 0xFFFF+2 accepts -> stat_in_cnt=1; undefined -> both stat ports constant 0.

Source files
------------

// File: rtl/fir_tap_ctrl_if.sv
// ---------------------------------------------------------------------------
// fir_tap_ctrl_if
// Streaming handshake bundle for fir_tap_ctrl.
//   s_valid/s_ready/s_data : upstream samples into the controller (WIDTH bits)
//   m_valid/m_ready/m_data : downstream moving sums out of the controller (OW bits)
// Modports:
//   slave  - the controller side (consumes s_*, produces m_*)
//   master - the environment side (produces s_*, consumes m_*)
// ---------------------------------------------------------------------------
interface fir_tap_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int OW    = 6
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [OW-1:0]    m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/fir_tap_ctrl.sv
// ---------------------------------------------------------------------------
// fir_tap_ctrl
// Controller wrapped around an external TAPS-deep moving-sum tap. It clears
// the tap after reset, meters samples into it with credit so that every sum
// in flight is guaranteed a slot in the output FIFO, and supports a flush that
// pushes TAPS zero samples through the tap so the tail sums drain downstream.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous, active-low
//   bus            fir_tap_ctrl_if.slave (s_valid/s_ready/s_data, m_valid/m_ready/m_data)
//   flush_req      one-cycle flush request (honoured only in RUN)
//   flush_done     one-cycle pulse when the flush has fully drained
//   busy           high whenever the controller is not in RUN
//   tap_reset      synchronous reset to the tap (held through INIT)
//   tap_valid      tap in_valid
//   tap_data       tap input sample
//   tap_out_valid  tap out_valid
//   tap_out        tap sum (OW bits)
//   stat_in_cnt    accepted-sample count (16-bit, wraps)
//   stat_out_cnt   delivered-sum count (16-bit, wraps)
//
// Build option: define FIR_TAP_CTRL_STATS_EN to include the statistics
// counters; otherwise both stat ports are tied to zero.
// ---------------------------------------------------------------------------
module fir_tap_ctrl #(
  parameter  int TAPS  = 4,
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int OW    = $clog2(TAPS) + WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  fir_tap_ctrl_if.slave     bus,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              busy,
  output logic              tap_reset,
  output logic              tap_valid,
  output logic [WIDTH-1:0]  tap_data,
  input  logic              tap_out_valid,
  input  logic [OW-1:0]     tap_out,
  output logic [15:0]       stat_in_cnt,
  output logic [15:0]       stat_out_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(TAPS + 1);

  typedef enum logic [1:0] {INIT, RUN, FLUSH, DRAIN} state_t;

  state_t          state;
  logic [IW-1:0]   init_cnt;
  logic [IW-1:0]   zero_left;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   fifo_cnt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [OW-1:0]   mem [DEPTH];

  logic credit_ok;
  logic accept;
  logic zero_issue;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit is judged on registered occupancy only: a pop in this cycle does
  // not free a slot until the next one, which keeps s_ready off the m_ready path.
  assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_cnt}) < (CW + 1)'(DEPTH);
  assign bus.s_ready = (state == RUN) && !flush_req && credit_ok;
  assign accept     = bus.s_valid && bus.s_ready;
  assign zero_issue = (state == FLUSH) && (zero_left != '0) && credit_ok;

  assign tap_valid  = accept || zero_issue;
  assign tap_data   = accept ? bus.s_data : '0;
  assign tap_reset  = (state == INIT);
  assign busy       = (state != RUN);

  // Returns seen during INIT belong to traffic from before reset; drop them.
  assign push        = tap_out_valid && (state != INIT);
  assign bus.m_valid = (fifo_cnt != '0);
  assign pop         = bus.m_valid && bus.m_ready;
  assign bus.m_data  = bus.m_valid ? mem[rd_ptr] : '0;

  // ---- control stage: FSM, credit counters, FIFO pointers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      init_cnt   <= '0;
      zero_left  <= '0;
      inflight   <= '0;
      fifo_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;

      unique case (state)
        INIT: begin
          if (init_cnt == IW'(TAPS - 1)) begin
            init_cnt <= '0;
            state    <= RUN;
          end else begin
            init_cnt <= init_cnt + IW'(1);
          end
        end
        RUN: begin
          if (flush_req) begin
            zero_left <= IW'(TAPS);
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          if (zero_issue) begin
            zero_left <= zero_left - IW'(1);
            if (zero_left == IW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0 && fifo_cnt == '0) begin
            flush_done <= 1'b1;
            state      <= RUN;
          end
        end
        default: state <= INIT;
      endcase

      unique case ({tap_valid, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase

      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase

      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
    end
  end

  // ---- data stage: FIFO storage ----
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tap_out;
  end

`ifdef FIR_TAP_CTRL_STATS_EN
  // ---- statistics stage ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_in_cnt  <= '0;
      stat_out_cnt <= '0;
    end else begin
      if (accept) stat_in_cnt  <= stat_in_cnt + 16'd1;
      if (pop)    stat_out_cnt <= stat_out_cnt + 16'd1;
    end
  end
`else
  assign stat_in_cnt  = '0;
  assign stat_out_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_tap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_ctrl
// Scoreboard bench for fir_tap_ctrl with TAPS=4, WIDTH=4, DEPTH=8. Includes a
// behavioural moving-sum tap (window advances on in_valid, TAPS-cycle latency,
// cleared by tap_reset).
// ---------------------------------------------------------------------------
module tb_fir_tap_ctrl;
  localparam int TAPS  = 4;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int OW    = 6;

`ifdef FIR_TAP_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_tap_ctrl_if #(.WIDTH(WIDTH), .OW(OW)) bus ();

  logic             flush_req;
  logic             flush_done;
  logic             busy;
  logic             tap_reset;
  logic             tap_valid;
  logic [WIDTH-1:0] tap_data;
  logic             tap_out_valid;
  logic [OW-1:0]    tap_out;
  logic [15:0]      stat_in_cnt;
  logic [15:0]      stat_out_cnt;

  fir_tap_ctrl #(.TAPS(TAPS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .bus           (bus),
    .flush_req     (flush_req),
    .flush_done    (flush_done),
    .busy          (busy),
    .tap_reset     (tap_reset),
    .tap_valid     (tap_valid),
    .tap_data      (tap_data),
    .tap_out_valid (tap_out_valid),
    .tap_out       (tap_out),
    .stat_in_cnt   (stat_in_cnt),
    .stat_out_cnt  (stat_out_cnt)
  );

  // Behavioural tap
  logic [WIDTH-1:0] twin  [TAPS-1];
  logic [OW-1:0]    tpipe [TAPS];
  logic             tpv   [TAPS];

  always_ff @(posedge clk) begin
    if (tap_reset) begin
      for (int i = 0; i < TAPS - 1; i++) twin[i] <= '0;
      for (int i = 0; i < TAPS; i++) begin
        tpipe[i] <= '0;
        tpv[i]   <= 1'b0;
      end
    end else begin
      tpv[0]   <= tap_valid;
      tpipe[0] <= tap_valid ? (OW'(tap_data) + OW'(twin[0]) + OW'(twin[1]) + OW'(twin[2])) : '0;
      for (int i = 1; i < TAPS; i++) begin
        tpv[i]   <= tpv[i-1];
        tpipe[i] <= tpipe[i-1];
      end
      if (tap_valid) begin
        twin[0] <= tap_data;
        for (int i = 1; i < TAPS - 1; i++) twin[i] <= twin[i-1];
      end
    end
  end

  assign tap_out_valid = tpv[TAPS-1];
  assign tap_out       = tpipe[TAPS-1];

  // Scoreboard
  int            n_pass  = 0;
  int            n_total = 0;
  logic [OW-1:0] exp_q [$];
  logic [WIDTH-1:0] mwin [TAPS-1];
  bit            sb_off = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_push(input logic [WIDTH-1:0] d);
    logic [OW-1:0] s;
    s = OW'(d);
    for (int i = 0; i < TAPS - 1; i++) s = s + OW'(mwin[i]);
    for (int i = TAPS - 2; i > 0; i--) mwin[i] = mwin[i-1];
    mwin[0] = d;
    exp_q.push_back(s);
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < TAPS - 1; i++) mwin[i] = '0;
  endtask

  always @(negedge clk) begin : monitor
    logic [OW-1:0] e;
    if (rst_n && !sb_off && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got %0d, expected no output", bus.m_data);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", 32'(bus.m_data), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.s_ready;
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    if (ok) model_push(d);
    else chk("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_s_ready",    32'(bus.s_ready), 0);
    chk("rst_m_valid",    32'(bus.m_valid), 0);
    chk("rst_flush_done", 32'(flush_done),  0);
    chk("rst_busy",       32'(busy),        1);
    chk("rst_tap_valid",  32'(tap_valid),   0);
    chk("rst_tap_data",   32'(tap_data),    0);
    chk("rst_tap_reset",  32'(tap_reset),   1);
    chk("rst_m_data",     32'(bus.m_data),  0);
    chk("rst_stat_in",    32'(stat_in_cnt), 0);
    chk("rst_stat_out",   32'(stat_out_cnt), 0);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acc;
    int zeros;
    int dones;
    int stale;
    int n;
    logic [WIDTH-1:0] d;

    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    flush_req   = 1'b0;
    model_clear();

    // Reset state and INIT sequence
    repeat (3) tick();
    chk_reset_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      @(negedge clk);
      chk("init_busy",      32'(busy),        1);
      chk("init_tap_reset", 32'(tap_reset),   1);
      chk("init_s_ready",   32'(bus.s_ready), 0);
      tick();
    end
    @(negedge clk);
    chk("run_busy",      32'(busy),        0);
    chk("run_s_ready",   32'(bus.s_ready), 1);
    chk("run_tap_reset", 32'(tap_reset),   0);
    tick();

    // Samples 1,2,3,4 -> 1,3,6,10 with first result 4 edges after accept
    bus.m_ready = 1'b1;
    send(4'd1);
    fork
      begin
        repeat (TAPS) begin
          @(negedge clk);
          chk("latency_early", 32'(bus.m_valid), 0);
        end
        @(negedge clk);
        chk("latency_due", 32'(bus.m_valid), 1);
      end
      begin
        send(4'd2);
        send(4'd3);
        send(4'd4);
      end
    join
    wait_drain();
    chk("stat_in_a",  32'(stat_in_cnt),  STATS ? 4 : 0);
    chk("stat_out_a", 32'(stat_out_cnt), STATS ? 4 : 0);

    // Backpressure: credit stops at DEPTH, one pop frees exactly one accept
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    acc = 0;
    d   = 4'd1;
    for (int i = 0; i < 20; i++) begin
      bus.s_data = d;
      @(negedge clk);
      if (bus.s_ready) begin
        acc++;
        model_push(d);
        d = d + 4'd1;
      end
      tick();
    end
    chk("bp_accepts", acc, DEPTH);
    bus.s_data  = d;
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_same_cycle_credit", 32'(bus.s_ready), 0);
    tick();
    bus.m_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      bus.s_data = d;
      @(negedge clk);
      if (bus.s_ready) begin
        acc++;
        model_push(d);
        d = d + 4'd1;
      end
      tick();
    end
    chk("bp_one_more", acc, 1);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    wait_drain();

    // Flush after 5,5,5,5 -> tail 15,10,5,0
    send(4'd5);
    send(4'd5);
    send(4'd5);
    send(4'd5);
    wait_drain();
    for (int i = 0; i < TAPS; i++) model_push('0);
    flush_req   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 4'd9;
    @(negedge clk);
    chk("flush_prio_s_ready",   32'(bus.s_ready), 0);
    chk("flush_prio_tap_valid", 32'(tap_valid),   0);
    tick();
    flush_req   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    zeros = 0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tap_valid) begin
        zeros++;
        chk("flush_zero_data", 32'(tap_data), 0);
      end
      if (flush_done) dones++;
      tick();
    end
    chk("flush_zero_issues", zeros, TAPS);
    chk("flush_done_pulses", dones, 1);
    chk("flush_back_to_run", 32'(busy), 0);
    chk("flush_tail_left",   exp_q.size(), 0);
    chk("stat_in_b",  32'(stat_in_cnt),  STATS ? 17 : 0);
    chk("stat_out_b", 32'(stat_out_cnt), STATS ? 21 : 0);

    // Reset mid-FLUSH with 3 zero samples in flight
    bus.m_ready = 1'b0;
    send(4'd3);
    send(4'd7);
    repeat (8) tick();
    chk("pre_rst_m_valid", 32'(bus.m_valid), 1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      if (tap_valid) n++;
      tick();
    end
    chk("pre_rst_issued", n, 3);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_clear();
    repeat (2) tick();
    rst_n       = 1'b1;
    bus.m_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.m_valid) stale++;
      tick();
    end
    chk("post_rst_stale", stale, 0);
    chk("post_rst_busy", 32'(busy), 0);
    send(4'd2);
    wait_drain();

`ifdef FIR_TAP_CTRL_STATS_EN
    // Counter wrap: 0xFFFF+2 accepts from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20 && busy; i++) tick();
    sb_off      = 1'b1;
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 4'd1;
    acc = 0;
    for (int i = 0; i < 80000 && acc < 65537; i++) begin
      @(negedge clk);
      if (bus.s_ready) acc++;
      tick();
    end
    bus.s_valid = 1'b0;
    repeat (30) tick();
    chk("wrap_accepts", acc, 65537);
    chk("wrap_stat_in",  32'(stat_in_cnt),  1);
    chk("wrap_stat_out", 32'(stat_out_cnt), 1);
    sb_off = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
